// File: rtl/io_port_unit.sv
// Processor I/O port stage: buffered OUT path (FIFO, valid/ready drain) and latched IN holding register.
// Optional sticky drop flag on outOverflow when IO_OVERFLOW_FLAG_EN is defined.
module io_port_unit #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           outPortData,
    input  logic                       outSignalEn,
    output logic [WIDTH-1:0]           extOutData,
    output logic                       extOutValid,
    input  logic                       extOutReady,
    output logic [$clog2(DEPTH):0]     outCount,
    output logic                       outFull,
    input  logic [WIDTH-1:0]           extInData,
    input  logic                       extInValid,
    input  logic                       inReadEn,
`ifdef IO_OVERFLOW_FLAG_EN
    output logic                       outOverflow,
`endif
    output logic [WIDTH-1:0]           inPortData,
    output logic                       inPortFresh
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] in_data_q, in_data_d;
    logic             in_fresh_q, in_fresh_d;
    logic             push, pop;

    // A push into a full FIFO is accepted only when the same-cycle pop frees a slot.
    assign pop  = valid_q && extOutReady;
    assign push = outSignalEn && (!full_q || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        in_data_d  = in_data_q;
        in_fresh_d = in_fresh_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != CW'(0));
        full_d  = (count_d == CW'(DEPTH));
        // A capture overrides a same-cycle read: the new word is still unread.
        if (extInValid) begin
            in_data_d  = extInData;
            in_fresh_d = 1'b1;
        end else if (inReadEn) begin
            in_fresh_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            in_data_q  <= '0;
            in_fresh_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            in_data_q  <= in_data_d;
            in_fresh_q <= in_fresh_d;
        end
    end

    // Storage is never cleared; only the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= outPortData;
        end
    end

`ifdef IO_OVERFLOW_FLAG_EN
    logic ovf_q;
    logic drop;

    assign drop = outSignalEn && full_q && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign outOverflow = ovf_q;
`endif

    assign extOutData  = mem_q[rd_ptr_q];
    assign extOutValid = valid_q;
    assign outCount    = count_q;
    assign outFull     = full_q;
    assign inPortData  = in_data_q;
    assign inPortFresh = in_fresh_q;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: scoreboard queue for the OUT path, reference model for count and IN holder.
module tb_io_port_unit;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] outPortData;
    logic             outSignalEn;
    logic [WIDTH-1:0] extOutData;
    logic             extOutValid;
    logic             extOutReady;
    logic [3:0]       outCount;
    logic             outFull;
    logic [WIDTH-1:0] extInData;
    logic             extInValid;
    logic             inReadEn;
    logic [WIDTH-1:0] inPortData;
    logic             inPortFresh;
`ifdef IO_OVERFLOW_FLAG_EN
    logic             outOverflow;
`endif

    io_port_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .outPortData (outPortData),
        .outSignalEn (outSignalEn),
        .extOutData  (extOutData),
        .extOutValid (extOutValid),
        .extOutReady (extOutReady),
        .outCount    (outCount),
        .outFull     (outFull),
        .extInData   (extInData),
        .extInValid  (extInValid),
        .inReadEn    (inReadEn),
`ifdef IO_OVERFLOW_FLAG_EN
        .outOverflow (outOverflow),
`endif
        .inPortData  (inPortData),
        .inPortFresh (inPortFresh)
    );

    always #5 clk = ~clk;

    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] sb [$];
    int               mcnt = 0;
    logic             movf = 1'b0;
    logic [WIDTH-1:0] min_data = '0;
    logic             min_fresh = 1'b0;
    int               drained = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drained words are compared against the scoreboard just before the edge that accepts them.
    always @(negedge clk) begin
        if (!reset && extOutValid === 1'b1 && extOutReady === 1'b1) begin
            drained++;
            if (sb.size() == 0) begin
                check("drain_unexpected", 32'(extOutData), 32'hFFFF_FFFF);
            end else begin
                check("drain_data", 32'(extOutData), 32'(sb.pop_front()));
            end
        end
    end

    task automatic check_state();
        check("count", 32'(outCount), 32'(mcnt));
        check("valid", 32'(extOutValid), 32'(mcnt != 0));
        check("full", 32'(outFull), 32'(mcnt == DEPTH));
        check("in_data", 32'(inPortData), 32'(min_data));
        check("in_fresh", 32'(inPortFresh), 32'(min_fresh));
`ifdef IO_OVERFLOW_FLAG_EN
        check("overflow", 32'(outOverflow), 32'(movf));
`endif
    endtask

    task automatic step(input logic en, input logic [WIDTH-1:0] d, input logic rdy,
                        input logic iv, input logic [WIDTH-1:0] idata, input logic rd);
        logic pop_m, acc;
        outSignalEn = en;
        outPortData = d;
        extOutReady = rdy;
        extInValid  = iv;
        extInData   = idata;
        inReadEn    = rd;
        pop_m = (mcnt > 0) && rdy;
        acc   = en && ((mcnt < DEPTH) || pop_m);
        if (acc) sb.push_back(d);
        if (en && !acc) movf = 1'b1;
        mcnt = mcnt + (acc ? 1 : 0) - (pop_m ? 1 : 0);
        if (iv) begin
            min_data  = idata;
            min_fresh = 1'b1;
        end else if (rd) begin
            min_fresh = 1'b0;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Reset cycle also carries a push and a capture, both of which must be ignored.
    task automatic do_reset();
        reset       = 1'b1;
        outSignalEn = 1'b1;
        outPortData = 16'hDEAD;
        extOutReady = 1'b1;
        extInValid  = 1'b1;
        extInData   = 16'hCAFE;
        inReadEn    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        mcnt      = 0;
        movf      = 1'b0;
        min_data  = '0;
        min_fresh = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && mcnt != 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        outSignalEn = 1'b0; outPortData = '0; extOutReady = 1'b0;
        extInValid = 1'b0; extInData = '0; inReadEn = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Three queued words, then drained in order.
        for (int i = 1; i <= 3; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, '0, 1'b0);
        check("head_before_drain", 32'(extOutData), 32'h0001);
        drained = 0;
        drain();
        check("drained3", 32'(drained), 32'd3);

        // Overfill: ninth push dropped.
        for (int i = 0; i < 9; i++) step(1'b1, WIDTH'(16'h0100 + i), 1'b0, 1'b0, '0, 1'b0);
        drained = 0;
        drain();
        check("drained8", 32'(drained), 32'd8);

        // Full with simultaneous pop: push accepted, no overflow.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16'h0200 + i), 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, '0, 1'b0);
        drain();

        // Continuous streaming across two pointer wraps.
        drained = 0;
        for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(16'h3000 + i), 1'b1, 1'b0, '0, 1'b0);
        drain();
        check("drained20", 32'(drained), 32'd20);

        // Input holder: capture, read, capture+read, stale read.
        step(1'b0, '0, 1'b0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 16'h5678, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

        // Reset mid-queue discards everything.
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(16'h4000 + i), 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 16'h9999, 1'b0);
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("post_reset_drained_none", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_port_unit.md
# io_port_unit

Peripheral I/O stage sitting directly on the processor's port pins: it consumes the `outPortData`/`outSignalEn` write strobes produced by the execute stage and feeds `inPortData` back into decode. The output path buffers processor OUT writes in a FIFO and drains them over a valid/ready handshake, so a slow external consumer never loses back-to-back OUT instructions. The input path latches asynchronous-rate external words into a holding register with a freshness flag.

## Interface
Parameters:
- `DEPTH`, 8: output FIFO entries; power of two, ≥2.
- `WIDTH`, 16: data width of both paths.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `outPortData`  in  WIDTH  OUT-instruction data from the processor.
- `outSignalEn`  in  1  write strobe; one FIFO push per high cycle.
- `extOutData`  out  WIDTH  FIFO head word.
- `extOutValid`  out  1  FIFO non-empty.
- `extOutReady`  in  1  external consumer accepts head.
- `outCount`  out  log2(DEPTH)+1  current FIFO occupancy.
- `outFull`  out  1  `outCount == DEPTH`.
- `extInData`  in  WIDTH  external input word.
- `extInValid`  in  1  capture strobe for `extInData`.
- `inReadEn`  in  1  processor IN-instruction read strobe (IR in decode).
- `inPortData`  out  WIDTH  held input word to the processor.
- `inPortFresh`  out  1  word captured and not yet read.
- `outOverflow`  out  1  sticky drop flag (present only with `IO_OVERFLOW_FLAG_EN`).

## Operation
- Output FIFO: circular buffer, write/read pointers of log2(DEPTH) bits wrapping modulo DEPTH, separate occupancy counter.
- Push when `outSignalEn`; pop when `extOutValid && extOutReady`.
- Push and pop in the same cycle: both pointers advance, count unchanged — this holds when full (push accepted because the pop frees the slot) and at any intermediate occupancy.
- Empty: pop impossible (`extOutValid`=0); a push lands and count becomes 1.
- Full without pop: push dropped, memory and pointers unchanged.
- `extOutData` = entry at read pointer; undefined-but-stable contents when empty (bench ignores it when `extOutValid`=0).
- Input holder: on `extInValid`, `inPortData` <= `extInData`, `inPortFresh` <= 1. Else on `inReadEn`, `inPortFresh` <= 0; `inPortData` keeps its value.
- Capture and read in the same cycle: capture wins, `inPortFresh` stays 1 (processor consumed the old word; the new word is unread).
- `inReadEn` with `inPortFresh`=0: returns the stale held word, no error.

## Timing
- Reset (synchronous, takes effect at the edge with `reset`=1): pointers, `outCount`=0, `extOutValid`=0, `outFull`=0, `inPortData`=0, `inPortFresh`=0, `outOverflow`=0. FIFO memory not cleared. Reset mid-drain discards all queued words; pushes/captures in the reset cycle are ignored.
- Push latency: strobe sampled at edge N; `extOutValid`/`extOutData` reflect it from edge N (visible cycle N+1).
- Pop: head advances at the edge where valid&&ready; next word visible the following cycle. Sustained throughput one word/cycle.
- `outFull`, `outCount`, `extOutValid` are registered-state decodes, no combinational path from `outSignalEn` or `extOutReady`.
- `inPortData` valid to the processor one cycle after `extInValid`.

## Configuration
- `IO_OVERFLOW_FLAG_EN` defined: `outOverflow` port exists; set at the edge where a push is dropped (full, no pop), held until `reset`.
- Not defined: port absent, dropped pushes are silent; all other behaviour identical.

## Test plan
- Reset, then push 0x0001..0x0003 with `extOutReady`=0 -> `outCount`=3, `extOutData`=0x0001; raise ready -> 0x0001,0x0002,0x0003 on consecutive cycles, then `extOutValid`=0.
- DEPTH=8: push 9 words, ready=0 -> `outFull`=1, count 8, ninth word absent on drain; with macro `outOverflow`=1 after the ninth push.
- Full FIFO, push 0xBEEF with ready=1 in same cycle -> count stays 8, 0xBEEF is last word drained, `outOverflow` stays 0.
- Push/pop 20 words continuously at ready=1 -> pointers wrap twice, output order equals input order, count never exceeds 1.
- `extInValid` with 0x1234 -> `inPortData`=0x1234, fresh=1; `inReadEn` -> fresh=0; simultaneous `extInValid` 0x5678 and `inReadEn` -> `inPortData`=0x5678, fresh=1.
- Queue 4 words, assert `reset` one cycle -> `outCount`=0, `extOutValid`=0, `inPortFresh`=0 next cycle.
